// File: rtl/branch_pred_ctrl.sv
// Next-PC controller: direct-mapped BTB with 2-bit counters, EXE-stage resolution and flush.
// Optional BP_PERF_CNT_EN adds br_cnt / mispred_cnt resolution counters.

`ifndef PC_PLUS_4
`define PC_PLUS_4     2'b00
`endif
`ifndef IF_P_T_PC
`define IF_P_T_PC     2'b01
`endif
`ifndef EXE_T_PC
`define EXE_T_PC      2'b10
`endif
`ifndef EXE_PC_PLUS_4
`define EXE_PC_PLUS_4 2'b11
`endif

module branch_pred_btb_entry #(
    parameter int addrWidth = 16,
    parameter int TAG_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [addrWidth-1:0] i_target,
    input  logic [1:0]           i_ctr,
    output logic                 o_valid,
    output logic [TAG_W-1:0]     o_tag,
    output logic [addrWidth-1:0] o_target,
    output logic [1:0]           o_ctr
);
    logic                 r_valid;
    logic [TAG_W-1:0]     r_tag;
    logic [addrWidth-1:0] r_target;
    logic [1:0]           r_ctr;

    // Every write leaves the entry valid; there is no invalidate path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_tag    <= '0;
            r_target <= '0;
            r_ctr    <= 2'b01;
        end else if (i_we) begin
            r_valid  <= 1'b1;
            r_tag    <= i_tag;
            r_target <= i_target;
            r_ctr    <= i_ctr;
        end
    end

    assign o_valid  = r_valid;
    assign o_tag    = r_tag;
    assign o_target = r_target;
    assign o_ctr    = r_ctr;
endmodule

module branch_pred_ctrl #(
    parameter int addrWidth = 16,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Hcf,
    input  logic                 Stall,
    input  logic [addrWidth-1:0] IF_pc,
    input  logic                 EXE_is_branch,
    input  logic                 EXE_is_jump,
    input  logic                 EXE_taken,
    input  logic [addrWidth-1:0] EXE_pc,
    input  logic [addrWidth-1:0] EXE_Target_pc,
    input  logic                 EXE_pred_taken,
    input  logic [addrWidth-1:0] EXE_pred_target,
    output logic [1:0]           PCSel,
    output logic [addrWidth-1:0] Predict_Target_pc,
    output logic                 IF_pred_taken,
    output logic                 Flush
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]          br_cnt,
    output logic [31:0]          mispred_cnt
`endif
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = addrWidth - IDX_W - 2;

    logic [ENTRIES-1:0]                w_valid;
    logic [ENTRIES-1:0][TAG_W-1:0]     w_tag;
    logic [ENTRIES-1:0][addrWidth-1:0] w_target;
    logic [ENTRIES-1:0][1:0]           w_ctr;
    logic [ENTRIES-1:0]                w_we;

    logic [IDX_W-1:0] w_if_idx, w_exe_idx;
    logic [TAG_W-1:0] w_if_tag, w_exe_tag;
    logic             w_if_hit, w_exe_hit;
    logic             w_eff_taken, w_resolve, w_mispredict, w_upd;
    logic             w_wr;
    logic [addrWidth-1:0] w_new_target;
    logic [1:0]           w_new_ctr;
    logic             w_unused;

    assign w_unused = ^{IF_pc[1:0], EXE_pc[1:0]};

    assign w_if_idx  = IF_pc[IDX_W+1:2];
    assign w_if_tag  = IF_pc[addrWidth-1:IDX_W+2];
    assign w_exe_idx = EXE_pc[IDX_W+1:2];
    assign w_exe_tag = EXE_pc[addrWidth-1:IDX_W+2];

    assign w_if_hit  = w_valid[w_if_idx]  & (w_tag[w_if_idx]  == w_if_tag);
    assign w_exe_hit = w_valid[w_exe_idx] & (w_tag[w_exe_idx] == w_exe_tag);

    assign IF_pred_taken     = w_if_hit & w_ctr[w_if_idx][1];
    assign Predict_Target_pc = w_if_hit ? w_target[w_if_idx] : '0;

    assign w_eff_taken  = EXE_is_jump | EXE_taken;
    assign w_resolve    = EXE_is_branch | EXE_is_jump;
    assign w_mispredict = w_resolve &
                          ((EXE_pred_taken != w_eff_taken) |
                           (w_eff_taken & EXE_pred_taken & (EXE_pred_target != EXE_Target_pc)));
    assign w_upd        = w_resolve & ~Stall & ~Hcf;
    assign Flush        = w_mispredict & ~Stall & ~Hcf;

    always_comb begin
        PCSel = `PC_PLUS_4;
        if (w_mispredict & w_eff_taken)       PCSel = `EXE_T_PC;
        else if (w_mispredict)                PCSel = `EXE_PC_PLUS_4;
        else if (IF_pred_taken)               PCSel = `IF_P_T_PC;
    end

    // Write data for the EXE entry; jumps win if both type flags are set.
    always_comb begin
        w_wr         = 1'b0;
        w_new_target = w_target[w_exe_idx];
        w_new_ctr    = w_ctr[w_exe_idx];
        if (EXE_is_jump) begin
            w_wr         = 1'b1;
            w_new_target = EXE_Target_pc;
            w_new_ctr    = 2'b11;
        end else if (EXE_is_branch) begin
            if (w_exe_hit) begin
                w_wr = 1'b1;
                if (EXE_taken) begin
                    w_new_target = EXE_Target_pc;
                    if (w_ctr[w_exe_idx] != 2'b11) w_new_ctr = w_ctr[w_exe_idx] + 2'b01;
                end else begin
                    if (w_ctr[w_exe_idx] != 2'b00) w_new_ctr = w_ctr[w_exe_idx] - 2'b01;
                end
            end else if (EXE_taken) begin
                w_wr         = 1'b1;
                w_new_target = EXE_Target_pc;
                w_new_ctr    = 2'b10;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_entry
            assign w_we[g] = w_upd & w_wr & (w_exe_idx == IDX_W'(g));
            branch_pred_btb_entry #(
                .addrWidth(addrWidth),
                .TAG_W    (TAG_W)
            ) u_entry (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_we[g]),
                .i_tag   (w_exe_tag),
                .i_target(w_new_target),
                .i_ctr   (w_new_ctr),
                .o_valid (w_valid[g]),
                .o_tag   (w_tag[g]),
                .o_target(w_target[g]),
                .o_ctr   (w_ctr[g])
            );
        end
    endgenerate

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_br_cnt, r_mispred_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (w_upd) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispredict) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_branch_pred_ctrl;
    localparam logic [1:0] P4 = 2'b00, IFP = 2'b01, EXT = 2'b10, EXP4 = 2'b11;

    logic        clk = 1'b0, rst = 1'b1, Hcf = 1'b0, Stall = 1'b0;
    logic [15:0] IF_pc = 16'h0040;
    logic        EXE_is_branch = 1'b0, EXE_is_jump = 1'b0, EXE_taken = 1'b0, EXE_pred_taken = 1'b0;
    logic [15:0] EXE_pc = '0, EXE_Target_pc = '0, EXE_pred_target = '0;
    logic [1:0]  PCSel;
    logic [15:0] Predict_Target_pc;
    logic        IF_pred_taken, Flush;
`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt, mispred_cnt;
`endif

    branch_pred_ctrl #(.addrWidth(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .Hcf(Hcf), .Stall(Stall), .IF_pc(IF_pc),
        .EXE_is_branch(EXE_is_branch), .EXE_is_jump(EXE_is_jump), .EXE_taken(EXE_taken),
        .EXE_pc(EXE_pc), .EXE_Target_pc(EXE_Target_pc), .EXE_pred_taken(EXE_pred_taken),
        .EXE_pred_target(EXE_pred_target), .PCSel(PCSel), .Predict_Target_pc(Predict_Target_pc),
        .IF_pred_taken(IF_pred_taken), .Flush(Flush)
`ifdef BP_PERF_CNT_EN
        , .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [1:0]  sel;
        logic [15:0] tgt;
        logic        pred;
        logic        fl;
    } exp_t;

    exp_t q[$];
    int   nvec = 0, nerr = 0, vid = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            if (PCSel !== e.sel) begin
                nerr++; $display("FAIL vec%0d PCSel got %0h exp %0h", e.id, PCSel, e.sel);
            end
            if (Predict_Target_pc !== e.tgt) begin
                nerr++; $display("FAIL vec%0d Predict_Target_pc got %h exp %h", e.id, Predict_Target_pc, e.tgt);
            end
            if (IF_pred_taken !== e.pred) begin
                nerr++; $display("FAIL vec%0d IF_pred_taken got %0b exp %0b", e.id, IF_pred_taken, e.pred);
            end
            if (Flush !== e.fl) begin
                nerr++; $display("FAIL vec%0d Flush got %0b exp %0b", e.id, Flush, e.fl);
            end
        end
    end

    // One vector per cycle: drive just after posedge, expectation checked at the following negedge.
    task automatic step(input logic [15:0] ifpc, input bit br, input bit jmp, input bit tk,
                        input logic [15:0] epc, input logic [15:0] etgt, input bit ptk,
                        input logic [15:0] ptgt, input bit stl, input bit hcf, input bit arst,
                        input logic [1:0] xsel, input logic [15:0] xtgt, input bit xpred, input bit xfl);
        exp_t e;
        @(posedge clk); #1;
        IF_pc = ifpc; EXE_is_branch = br; EXE_is_jump = jmp; EXE_taken = tk;
        EXE_pc = epc; EXE_Target_pc = etgt; EXE_pred_taken = ptk; EXE_pred_target = ptgt;
        Stall = stl; Hcf = hcf; rst = arst;
        e.id = vid; e.sel = xsel; e.tgt = xtgt; e.pred = xpred; e.fl = xfl;
        q.push_back(e);
        vid++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        //    IF_pc    br jp tk EXE_pc   target   ptk ptgt     st hc rs  PCSel  tgt      pred fl
        step(16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, P4,   16'h0000, 0, 0); // reset state
        step(16'h0040, 1, 0, 1, 16'h0040, 16'h0100, 0, 16'h0000, 0, 0, 0, EXT,  16'h0000, 0, 1); // alloc, pre-update lookup
        step(16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, IFP,  16'h0100, 1, 0);
        step(16'h0040, 1, 0, 0, 16'h0040, 16'h0100, 1, 16'h0100, 0, 0, 0, EXP4, 16'h0100, 1, 1); // ctr 10->01
        step(16'h0040, 1, 0, 0, 16'h0040, 16'h0100, 1, 16'h0100, 0, 0, 0, EXP4, 16'h0100, 0, 1); // ctr 01->00
        step(16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, P4,   16'h0100, 0, 0);
        step(16'h0044, 1, 0, 0, 16'h0044, 16'h0700, 0, 16'h0000, 0, 0, 0, P4,   16'h0000, 0, 0); // miss not-taken
        step(16'h0044, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, P4,   16'h0000, 0, 0); // no allocation
        step(16'h0080, 0, 1, 0, 16'h0080, 16'h0300, 1, 16'h0200, 0, 0, 0, EXT,  16'h0000, 0, 1); // JAL wrong target
        step(16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, IFP,  16'h0300, 1, 0);
        step(16'h0040, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, P4,   16'h0000, 0, 0); // evicted
        step(16'h0080, 1, 0, 1, 16'h0080, 16'h0300, 1, 16'h0300, 0, 0, 0, IFP,  16'h0300, 1, 0); // correct pred
        step(16'h0080, 1, 0, 1, 16'h0080, 16'h0340, 1, 16'h0300, 0, 0, 0, EXT,  16'h0300, 1, 1); // target mismatch
        step(16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, IFP,  16'h0340, 1, 0);
        for (int i = 0; i < 3; i++)
            step(16'h0048, 1, 0, 1, 16'h0048, 16'h0500, 0, 16'h0000, 1, 0, 0, EXT, 16'h0000, 0, 0); // stalled
        step(16'h0048, 1, 0, 1, 16'h0048, 16'h0500, 0, 16'h0000, 0, 0, 0, EXT,  16'h0000, 0, 1); // stall dropped
        step(16'h0048, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, IFP,  16'h0500, 1, 0);
        step(16'h0048, 1, 0, 0, 16'h0048, 16'h0500, 1, 16'h0500, 0, 0, 0, EXP4, 16'h0500, 1, 1); // 10->01 if single update
        step(16'h0048, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, P4,   16'h0500, 0, 0);
        step(16'h004C, 1, 0, 1, 16'h004C, 16'h0600, 0, 16'h0000, 0, 1, 0, EXT,  16'h0000, 0, 0); // halted
        step(16'h004C, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, P4,   16'h0000, 0, 0); // no update
`ifdef BP_PERF_CNT_EN
        @(negedge clk); #1;
        nvec++;
        if (br_cnt !== 32'd9) begin
            nerr++; $display("FAIL br_cnt got %0d exp 9", br_cnt);
        end
        nvec++;
        if (mispred_cnt !== 32'd7) begin
            nerr++; $display("FAIL mispred_cnt got %0d exp 7", mispred_cnt);
        end
`endif
        step(16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, IFP,  16'h0340, 1, 0);
        step(16'h0080, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, P4,   16'h0000, 0, 0); // async reset clears
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nerr++; $display("FAIL drain pending %0d exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
